// File: rtl/sdp_rdma_group_ctrl_pkg.sv
// Shared definitions for the SDP RDMA ping-pong register-group controller:
// group status encodings and group index constants.
package sdp_rdma_group_ctrl_pkg;

    typedef enum logic [1:0] {
        SDP_RDMA_GRP_IDLE = 2'd0,
        SDP_RDMA_GRP_RUN  = 2'd1,
        SDP_RDMA_GRP_PEND = 2'd2
    } sdp_rdma_grp_status_e;

    localparam logic SDP_RDMA_GRP0 = 1'b0;
    localparam logic SDP_RDMA_GRP1 = 1'b1;

endpackage

// File: rtl/sdp_rdma_group_state.sv
// One register group: its op_en flop (set has priority over clear) and the
// IDLE/RUNNING/PENDING status decode.
module sdp_rdma_group_state
    import sdp_rdma_group_ctrl_pkg::*;
(
    input  logic       nvdla_core_clk,
    input  logic       nvdla_core_rstn,
    input  logic       set,
    input  logic       clr,
    input  logic       is_consumer,
    output logic       grp_op_en,
    output logic [1:0] status
);

    // Firmware re-arming the group in the same cycle its operation finishes must not be lost.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            grp_op_en <= 1'b0;
        end else if (set) begin
            grp_op_en <= 1'b1;
        end else if (clr) begin
            grp_op_en <= 1'b0;
        end
    end

    always_comb begin
        status = SDP_RDMA_GRP_IDLE;
        if (grp_op_en) begin
            status = is_consumer ? SDP_RDMA_GRP_RUN : SDP_RDMA_GRP_PEND;
        end
    end

endmodule

// File: rtl/sdp_rdma_group_ctrl.sv
// SDP RDMA dual register-group controller: tracks the consumer group and drives
// op_en/op_load to the read engine. Define SDP_RDMA_GROUP_PERF_EN for the cycle counter.
module sdp_rdma_group_ctrl
    import sdp_rdma_group_ctrl_pkg::*;
#(
    parameter int PERF_CNT_W = 32,
    parameter int STATUS_W   = 2
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  producer,
    input  logic                  d0_op_en_trigger,
    input  logic                  d1_op_en_trigger,
    input  logic                  reg_wr_data0,
    input  logic                  dp_op_done,
    output logic                  consumer,
    output logic [STATUS_W-1:0]   status_0,
    output logic [STATUS_W-1:0]   status_1,
    output logic                  d0_op_en,
    output logic                  d1_op_en,
    output logic                  op_en,
    output logic                  op_load,
    output logic [PERF_CNT_W-1:0] perf_op_cycles
);

    if (STATUS_W != 2) begin : g_bad_status_w
        $error("sdp_rdma_group_ctrl: STATUS_W must be 2");
    end

    logic       accepted_done;
    logic       op_en_nxt;
    logic       op_load_nxt;
    logic [1:0] grp0_status;
    logic [1:0] grp1_status;
    logic       unused_producer;

    // producer is only reflected back through the register file.
    assign unused_producer = producer;

    assign accepted_done = dp_op_done & op_en;
    assign op_en_nxt     = (consumer ? d1_op_en : d0_op_en) & ~accepted_done;
    assign op_load_nxt   = op_en_nxt & ~op_en;

    sdp_rdma_group_state u_grp0 (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .set             (d0_op_en_trigger & reg_wr_data0),
        .clr             (accepted_done & (consumer == SDP_RDMA_GRP0)),
        .is_consumer     (consumer == SDP_RDMA_GRP0),
        .grp_op_en       (d0_op_en),
        .status          (grp0_status)
    );

    sdp_rdma_group_state u_grp1 (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .set             (d1_op_en_trigger & reg_wr_data0),
        .clr             (accepted_done & (consumer == SDP_RDMA_GRP1)),
        .is_consumer     (consumer == SDP_RDMA_GRP1),
        .grp_op_en       (d1_op_en),
        .status          (grp1_status)
    );

    assign status_0 = grp0_status;
    assign status_1 = grp1_status;

    // Forcing op_en low on the done cycle guarantees a gap, so every operation gets its own op_load.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            consumer <= 1'b0;
            op_en    <= 1'b0;
            op_load  <= 1'b0;
        end else begin
            consumer <= consumer ^ accepted_done;
            op_en    <= op_en_nxt;
            op_load  <= op_load_nxt;
        end
    end

`ifdef SDP_RDMA_GROUP_PERF_EN
    logic [PERF_CNT_W-1:0] perf_cnt;

    // Counts every cycle op_en is high, done cycle included; op_en then drops so the value holds.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            perf_cnt <= '0;
        end else if (op_load_nxt) begin
            perf_cnt <= '0;
        end else if (op_en && (perf_cnt != {PERF_CNT_W{1'b1}})) begin
            perf_cnt <= perf_cnt + 1'b1;
        end
    end

    assign perf_op_cycles = perf_cnt;
`else
    assign perf_op_cycles = '0;
`endif

endmodule
